// File: rtl/regset_write_arbiter.sv
// regset_write_arbiter: round-robin arbiter for the register set's single write port, with optional post-reset clear
// Ports: clk; res (sync, active-low); req_valid/req_ready/req_data/req_reg per requester;
//        write/write_reg/write_enable registered towards the register set; busy while clearing.
// Build option: define REGSET_CLEAR_EN to zero registers 1..RegisterCount-1 after every reset.
`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif
module regset_write_arbiter #(
    parameter int RegisterCount = `REGISTER_COUNT,
    parameter int Requesters = 3,
    parameter int Width = 32,
    parameter int RegBits = $clog2(RegisterCount),
    parameter int PtrBits = $clog2(Requesters)
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [Requesters-1:0]         req_valid,
    output logic [Requesters-1:0]         req_ready,
    input  logic [Requesters*Width-1:0]   req_data,
    input  logic [Requesters*RegBits-1:0] req_reg,
    output logic [Width-1:0]              write,
    output logic [RegBits-1:0]            write_reg,
    output logic                          write_enable,
    output logic                          busy
);
    logic [PtrBits-1:0] ptr, sel;
    logic               found, run;
    logic [RegBits-1:0] sel_reg, clr_reg;
    logic [Width-1:0]   sel_data;
`ifdef REGSET_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_n;
    logic [RegBits-1:0] cnt;
    always_ff @(posedge clk) state <= res ? state_n : CLEAR;
    always_comb state_n = (state == CLEAR && cnt == RegBits'(RegisterCount - 1)) ? RUN : state;
    always_ff @(posedge clk) cnt <= !res ? RegBits'(1) : run ? cnt : cnt + 1'b1;
    assign run = state == RUN;
    assign clr_reg = cnt;
`else
    assign run = 1'b1;
    assign clr_reg = '0;
`endif
    assign busy = !run;
    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        int j;
        j = 0;
        found = 1'b0;
        sel = '0;
        for (int k = 0; k < Requesters; k++) begin
            j = int'(ptr) + k;
            if (j >= Requesters) j -= Requesters;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                sel = PtrBits'(j);
            end
        end
    end
    assign req_ready = (run && found) ? Requesters'(1) << sel : '0;
    assign sel_data = req_data[int'(sel)*Width +: Width];
    assign sel_reg = req_reg[int'(sel)*RegBits +: RegBits];
    always_ff @(posedge clk) begin
        if (!res) begin
            write_enable <= 1'b0;
            write <= '0;
            write_reg <= '0;
            ptr <= '0;
        end else if (busy) begin
            write_enable <= 1'b1;
            write <= '0;
            write_reg <= clr_reg;
        end else if (found) begin
            // Writes to register 0 are accepted but never strobed.
            write_enable <= sel_reg != '0;
            write <= sel_data;
            write_reg <= sel_reg;
            ptr <= (sel == PtrBits'(Requesters - 1)) ? '0 : sel + 1'b1;
        end else begin
            write_enable <= 1'b0;
        end
    end
endmodule
